// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Multi-cycle control sequencer for a simple CPU datapath.
//            Steps T0..T6/HALT, decodes datapath strobes and the ALU opcode,
//            flags illegal opcodes and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic [18:0] strobes,
  output logic [4:0]  opcode,
  output logic        done,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  // Sequencer states
  localparam logic [2:0] T0   = 3'd0;
  localparam logic [2:0] T1   = 3'd1;
  localparam logic [2:0] T2   = 3'd2;
  localparam logic [2:0] T3   = 3'd3;
  localparam logic [2:0] T4   = 3'd4;
  localparam logic [2:0] T5   = 3'd5;
  localparam logic [2:0] T6   = 3'd6;
  localparam logic [2:0] HALT = 3'd7;

  // One-hot masks for each strobe bit
  localparam logic [18:0] B_PCOUT    = 19'b1 << 0;
  localparam logic [18:0] B_INCPC    = 19'b1 << 1;
  localparam logic [18:0] B_MARIN    = 19'b1 << 2;
  localparam logic [18:0] B_ZIN      = 19'b1 << 3;
  localparam logic [18:0] B_PCIN     = 19'b1 << 4;
  localparam logic [18:0] B_MDRIN    = 19'b1 << 5;
  localparam logic [18:0] B_READ     = 19'b1 << 6;
  localparam logic [18:0] B_IRIN     = 19'b1 << 7;
  localparam logic [18:0] B_YIN      = 19'b1 << 8;
  localparam logic [18:0] B_ZLOWOUT  = 19'b1 << 9;
  localparam logic [18:0] B_ZHIGHOUT = 19'b1 << 10;
  localparam logic [18:0] B_MDROUT   = 19'b1 << 11;
  localparam logic [18:0] B_GRA      = 19'b1 << 12;
  localparam logic [18:0] B_GRB      = 19'b1 << 13;
  localparam logic [18:0] B_GRC      = 19'b1 << 14;
  localparam logic [18:0] B_RIN      = 19'b1 << 15;
  localparam logic [18:0] B_ROUT     = 19'b1 << 16;
  localparam logic [18:0] B_LOIN     = 19'b1 << 17;
  localparam logic [18:0] B_HIIN     = 19'b1 << 18;

  logic [2:0]  state_q, state_d;
  logic        hilo_q, hilo_d;        // current instruction writes HI/LO
  logic        illegal_q, illegal_d;
  logic [15:0] instr_count_q, instr_count_d;

  logic [4:0]  op;
  logic        op_alu, op_hilo, op_nop, op_halt, op_undef;
  logic [18:0] strobe_dec;
  logic [4:0]  opcode_dec;
  logic        done_dec;
  logic        unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = &{1'b0, IR[26:0]};

  // Classify the opcode field of the instruction register
  always_comb begin
    op_alu   = (op >= 5'd3) && (op <= 5'd11);
    op_hilo  = (op == 5'd15) || (op == 5'd16);
    op_nop   = (op == 5'd26);
    op_halt  = (op == 5'd27);
    op_undef = !(op_alu || op_hilo || op_nop || op_halt);
  end

  // Next-state logic; T2 branches on the freshly loaded opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      T0:      state_d = run ? T1 : T0;
      T1:      state_d = mem_ready ? T2 : T1;
      T2: begin
        if (op_alu || op_hilo) state_d = T3;
        else if (op_halt)      state_d = HALT;
        else                   state_d = T0;
      end
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = hilo_q ? T6 : T0;
      T6:      state_d = T0;
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase
  end

  // Side state: instruction class, sticky illegal flag, retire counter
  always_comb begin
    hilo_d        = (state_q == T2) ? op_hilo : hilo_q;
    illegal_d     = illegal_q | ((state_q == T2) && op_undef);
    instr_count_d = instr_count_q + 16'd1;
  end

  // Output decode from the current state (T0/T1 also qualify on run/mem_ready)
  always_comb begin
    strobe_dec = '0;
    opcode_dec = '0;
    done_dec   = 1'b0;
    case (state_q)
      T0: if (run) strobe_dec = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
      T1: strobe_dec = B_ZLOWOUT | B_READ | B_MDRIN | (mem_ready ? B_PCIN : '0);
      T2: begin
        strobe_dec = B_MDROUT | B_IRIN;
        done_dec   = !(op_alu || op_hilo);
      end
      T3: strobe_dec = B_GRB | B_ROUT | B_YIN;
      T4: begin
        strobe_dec = B_GRC | B_ROUT | B_ZIN;
        opcode_dec = op;
      end
      T5: begin
        strobe_dec = hilo_q ? (B_ZLOWOUT | B_LOIN) : (B_ZLOWOUT | B_GRA | B_RIN);
        done_dec   = !hilo_q;
      end
      T6: begin
        strobe_dec = B_ZHIGHOUT | B_HIIN;
        done_dec   = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state registers with asynchronous clear
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= T0;
      hilo_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hilo_q    <= hilo_d;
      illegal_q <= illegal_d;
    end
  end

  // Retired-instruction counter, advances only on a retire pulse
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)        instr_count_q <= '0;
    else if (done_dec) instr_count_q <= instr_count_d;
  end

  // Outputs are gated by clear so reset silences them without a clock edge
  assign strobes     = clear ? strobe_dec : '0;
  assign opcode      = clear ? opcode_dec : '0;
  assign done        = clear & done_dec;
  assign halted      = clear & (state_q == HALT);
  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Purpose  : Self-checking bench for ctrl_sequencer with a cycle model and an
//            expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] IR;
  logic [18:0] strobes;
  logic [4:0]  opcode;
  logic        done, halted, illegal;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_BAD  = 5'b11111;

  localparam logic [18:0] BUS_MASK = 19'b001_0000_1110_0000_0001; // 0,9,10,11,16

  typedef struct packed {
    logic [18:0] stb;
    logic [4:0]  opc;
    logic        dn;
    logic        hlt;
    logic        ill;
    logic [15:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  // reference model state: 0..6 = T0..T6, 7 = HALT
  int          m_st;
  bit          m_hilo, m_ill;
  logic [15:0] m_cnt;

  always #5 clock = ~clock;

  ctrl_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .run         (run),
    .mem_ready   (mem_ready),
    .IR          (IR),
    .strobes     (strobes),
    .opcode      (opcode),
    .done        (done),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  function automatic logic [18:0] b(input int n);
    logic [18:0] one;
    one = 19'd1;
    return one << n;
  endfunction

  // 0 = ALU, 1 = HI/LO, 2 = nop, 3 = halt, 4 = undefined
  function automatic int op_class(input logic [4:0] o);
    if (o inside {[5'd3:5'd11]})    return 0;
    if (o == 5'd15 || o == 5'd16)   return 1;
    if (o == 5'd26)                 return 2;
    if (o == 5'd27)                 return 3;
    return 4;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_hilo = 0; m_ill = 0; m_cnt = 16'h0000;
  endfunction

  function automatic obs_t model_out(input logic r, input logic mr, input logic [4:0] o);
    obs_t e;
    e = '0;
    case (m_st)
      0: if (r) e.stb = b(0) | b(1) | b(2) | b(3);
      1: e.stb = b(9) | b(6) | b(5) | (mr ? b(4) : 19'd0);
      2: begin e.stb = b(11) | b(7); e.dn = (op_class(o) >= 2); end
      3: e.stb = b(13) | b(16) | b(8);
      4: begin e.stb = b(14) | b(16) | b(3); e.opc = o; end
      5: begin
        e.stb = m_hilo ? (b(9) | b(17)) : (b(9) | b(12) | b(15));
        e.dn  = !m_hilo;
      end
      6: begin e.stb = b(10) | b(18); e.dn = 1'b1; end
      default: e.hlt = 1'b1;
    endcase
    e.ill = m_ill;
    e.cnt = m_cnt;
    return e;
  endfunction

  function automatic void model_advance(input logic r, input logic mr, input logic [4:0] o,
                                        input logic dn);
    if (dn) m_cnt = m_cnt + 16'd1;
    case (m_st)
      0: m_st = r ? 1 : 0;
      1: m_st = mr ? 2 : 1;
      2: case (op_class(o))
           0: begin m_hilo = 0; m_st = 3; end
           1: begin m_hilo = 1; m_st = 3; end
           3: m_st = 7;
           4: begin m_ill = 1; m_st = 0; end
           default: m_st = 0;
         endcase
      3: m_st = 4;
      4: m_st = 5;
      5: m_st = m_hilo ? 6 : 0;
      6: m_st = 0;
      default: m_st = 7;
    endcase
  endfunction

  // Drive one clock cycle, queue the model's expectation, then score the DUT
  task automatic step(input logic r, input logic mr, input logic [4:0] o, input logic clr);
    obs_t e, a;
    @(negedge clock);
    run = r; mem_ready = mr; IR = {o, 27'h1234567}; clear = clr;
    if (!clr) model_reset();
    e = model_out(r, mr, o);
    if (!clr) e.stb = '0;
    exp_q.push_back(e);
    #1;
    a = {strobes, opcode, done, halted, illegal, instr_count};
    e = exp_q.pop_front();
    n_checks++;
    if (a.stb !== e.stb) begin
      n_fail++; $display("FAIL strobes st=%0d: got %h expected %h", m_st, a.stb, e.stb);
    end
    n_checks++;
    if (a.opc !== e.opc) begin
      n_fail++; $display("FAIL opcode st=%0d: got %h expected %h", m_st, a.opc, e.opc);
    end
    n_checks++;
    if (a.dn !== e.dn) begin
      n_fail++; $display("FAIL done st=%0d: got %b expected %b", m_st, a.dn, e.dn);
    end
    n_checks++;
    if (a.hlt !== e.hlt) begin
      n_fail++; $display("FAIL halted st=%0d: got %b expected %b", m_st, a.hlt, e.hlt);
    end
    n_checks++;
    if (a.ill !== e.ill) begin
      n_fail++; $display("FAIL illegal st=%0d: got %b expected %b", m_st, a.ill, e.ill);
    end
    n_checks++;
    if (a.cnt !== e.cnt) begin
      n_fail++; $display("FAIL instr_count st=%0d: got %h expected %h", m_st, a.cnt, e.cnt);
    end
    n_checks++;
    if ($countones(a.stb & BUS_MASK) > 1) begin
      n_fail++; $display("FAIL bus_drivers: got %h expected at most one bus driver", a.stb & BUS_MASK);
    end
    if (clr) model_advance(r, mr, o, e.dn);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, OP_ADD, 1'b0);
    step(1'b1, 1'b1, OP_ADD, 1'b0);
    n_checks++;
    if (strobes !== 19'd0 || instr_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h expected 0/0", strobes, instr_count);
    end
    step(1'b0, 1'b0, OP_ADD, 1'b1);
  endtask

  task automatic test_alu();
    step(1'b1, 1'b1, OP_ADD, 1'b1);           // T0
    step(1'b1, 1'b1, OP_ADD, 1'b1);           // T1
    step(1'b1, 1'b1, OP_ADD, 1'b1);           // T2
    step(1'b1, 1'b1, OP_ADD, 1'b1);           // T3
    step(1'b1, 1'b1, OP_ADD, 1'b1);           // T4
    n_checks++;
    if (opcode !== OP_ADD) begin
      n_fail++; $display("FAIL alu_opcode_t4: got %b expected %b", opcode, OP_ADD);
    end
    step(1'b0, 1'b1, OP_ADD, 1'b1);           // T5
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL alu_done_t5: got %b expected 1", done);
    end
    step(1'b0, 1'b0, OP_ADD, 1'b1);           // T0 idle
    n_checks++;
    if (instr_count !== 16'd1) begin
      n_fail++; $display("FAIL alu_count: got %0d expected 1", instr_count);
    end
  endtask

  task automatic test_wait();
    int reads, pcins;
    reads = 0; pcins = 0;
    step(1'b1, 1'b0, OP_NOP, 1'b1);           // T0
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 3), OP_NOP, 1'b1);     // T1 x4
      if (strobes[6] && strobes[5]) reads++;
      if (strobes[4]) pcins++;
      if (i == 3) begin
        n_checks++;
        if (strobes[4] !== 1'b1) begin
          n_fail++; $display("FAIL wait_pcin_last: got %b expected 1", strobes[4]);
        end
      end
    end
    n_checks++;
    if (reads != 4 || pcins != 1) begin
      n_fail++; $display("FAIL wait_counts: got read=%0d pcin=%0d expected read=4 pcin=1", reads, pcins);
    end
    step(1'b0, 1'b0, OP_NOP, 1'b1);           // T2 nop
    step(1'b0, 1'b0, OP_NOP, 1'b1);           // T0 idle
  endtask

  task automatic test_hilo(input logic [4:0] o);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, o, 1'b1);  // T0..T4
    step(1'b0, 1'b1, o, 1'b1);                              // T5
    n_checks++;
    if (strobes[17] !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL hilo_t5 op=%b: got lo=%b done=%b expected lo=1 done=0", o, strobes[17], done);
    end
    step(1'b0, 1'b1, o, 1'b1);                              // T6
    n_checks++;
    if (strobes[18] !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL hilo_t6 op=%b: got hi=%b done=%b expected hi=1 done=1", o, strobes[18], done);
    end
    step(1'b0, 1'b0, o, 1'b1);                              // T0 idle
  endtask

  task automatic test_illegal();
    step(1'b1, 1'b1, OP_BAD, 1'b1);
    step(1'b0, 1'b1, OP_BAD, 1'b1);
    step(1'b0, 1'b1, OP_BAD, 1'b1);           // T2
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL illegal_done: got %b expected 1", done);
    end
    step(1'b0, 1'b0, OP_BAD, 1'b1);           // back in T0
    n_checks++;
    if (illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_set: got %b expected 1", illegal);
    end
    for (int i = 0; i < 6; i++) step((i == 0), 1'b1, OP_ADD, 1'b1);
    step(1'b0, 1'b0, OP_ADD, 1'b1);
    n_checks++;
    if (illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_sticky: got %b expected 1", illegal);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] start;
    start = m_cnt;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, OP_ADD, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, OP_SUB, 1'b1);
    step(1'b1, 1'b1, OP_ADD, 1'b1);                          // T0
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, OP_ADD, 1'b1); // run falls, T1..T5
    step(1'b0, 1'b1, OP_ADD, 1'b1);
    step(1'b0, 1'b1, OP_ADD, 1'b1);
    n_checks++;
    if (instr_count !== start + 16'd3 || strobes !== 19'd0) begin
      n_fail++; $display("FAIL b2b_idle: got cnt=%h stb=%h expected cnt=%h stb=0", instr_count, strobes, start + 16'd3);
    end
  endtask

  task automatic test_halt();
    step(1'b1, 1'b1, OP_HALT, 1'b1);
    step(1'b1, 1'b1, OP_HALT, 1'b1);
    step(1'b1, 1'b1, OP_HALT, 1'b1);          // T2
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, OP_ADD, 1'b1);
      n_checks++;
      if (halted !== 1'b1 || strobes !== 19'd0) begin
        n_fail++; $display("FAIL halt_hold cyc=%0d: got h=%b stb=%h expected h=1 stb=0", i, halted, strobes);
      end
    end
    step(1'b1, 1'b1, OP_ADD, 1'b0);
    step(1'b0, 1'b1, OP_ADD, 1'b1);
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_cleared: got %b expected 0", halted);
    end
    step(1'b1, 1'b1, OP_ADD, 1'b1);           // T0 fetch restarts
    step(1'b0, 1'b0, OP_ADD, 1'b1);           // T1 wait
    step(1'b0, 1'b1, OP_NOP, 1'b1);           // T1 ready
    step(1'b0, 1'b1, OP_NOP, 1'b1);           // T2 nop
  endtask

  task automatic test_wrap_and_clear();
    step(1'b0, 1'b0, OP_NOP, 1'b0);
    step(1'b0, 1'b0, OP_NOP, 1'b1);
    force dut.instr_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut.instr_count_q;
    step(1'b0, 1'b0, OP_NOP, 1'b1);
    step(1'b1, 1'b1, OP_NOP, 1'b1);
    step(1'b0, 1'b1, OP_NOP, 1'b1);
    step(1'b0, 1'b1, OP_NOP, 1'b1);           // T2 done
    step(1'b0, 1'b0, OP_NOP, 1'b1);
    n_checks++;
    if (instr_count !== 16'h0000) begin
      n_fail++; $display("FAIL count_wrap: got %h expected 0000", instr_count);
    end
    for (int i = 0; i < 4; i++) step((i == 0), 1'b1, OP_ADD, 1'b1); // to T3
    n_checks++;
    if (strobes !== (b(13) | b(16) | b(8))) begin
      n_fail++; $display("FAIL t3_strobes: got %h expected %h", strobes, b(13) | b(16) | b(8));
    end
    clear = 1'b0;
    #1;
    n_checks++;
    if (strobes !== 19'd0 || opcode !== 5'd0) begin
      n_fail++; $display("FAIL async_clear: got stb=%h opc=%h expected 0/0", strobes, opcode);
    end
    model_reset();
    step(1'b1, 1'b1, OP_ADD, 1'b0);
    step(1'b0, 1'b0, OP_ADD, 1'b1);
  endtask

  initial begin
    clear = 1'b0; run = 1'b0; mem_ready = 1'b0; IR = 32'd0;
    model_reset();
    test_reset();
    test_alu();
    test_wait();
    test_hilo(OP_MUL);
    test_hilo(OP_DIV);
    test_illegal();
    test_back_to_back();
    test_halt();
    test_wrap_and_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port clear, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port run, input, 1, level enable; sampled only in T0.
REQ-004 SHALL have port mem_ready, input, 1, memory read data valid in the current cycle.
REQ-005 SHALL have port IR, input, 32, current instruction register contents.
REQ-006 SHALL have port strobes, output, 19, datapath control strobes, bit map per REQ-010.
REQ-007 SHALL have port opcode, output, 5, ALU operation select.
REQ-008 SHALL have ports done, halted and illegal, output, 1 each: retire pulse, halt state flag and sticky illegal-opcode flag.
REQ-009 SHALL have port instr_count, output, 16, count of retired instructions.

Function
REQ-010 SHALL map strobes bits 0..18 to: PCout, IncPC, MARin, Zin, PCin, MDRin, Read, IRin, Yin, ZLowout, ZHighout, MDRout, Gra, Grb, Grc, Rin, Rout, LOin, HIin.
REQ-011 SHALL implement states T0, T1, T2, T3, T4, T5, T6 and HALT, with a registered state and Moore-decoded strobes/opcode/done/halted.
REQ-012 SHALL in T0 assert nothing when run=0 and remain in T0; when run=1 assert PCout, MARin, IncPC and Zin, then go to T1.
REQ-013 SHALL in T1 assert ZLowout, Read and MDRin every cycle, and assert PCin only while mem_ready=1.
REQ-014 SHALL stay in T1 while mem_ready=0 (wait state, no cycle limit) and go to T2 on mem_ready=1.
REQ-015 SHALL in T2 assert MDRout and IRin, then branch on IR[31:27] as it stands after the T2 edge.
REQ-016 SHALL treat as ALU ops add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010 and rol 01011.
REQ-017 SHALL treat mul 01111 and div 10000 as HI/LO ops, nop 11010 as no-op and halt 11011 as halt.
REQ-018 SHALL route ALU and HI/LO ops T2->T3->T4->T5.
REQ-019 SHALL in T3 assert Grb, Rout and Yin.
REQ-020 SHALL in T4 assert Grc, Rout and Zin, and drive opcode=IR[31:27]; opcode SHALL be 00000 in every other state.
REQ-021 SHALL in T5 assert ZLowout with Gra and Rin for ALU ops (then T0), or ZLowout with LOin for HI/LO ops (then T6).
REQ-022 SHALL in T6 assert ZHighout and HIin, then go to T0.
REQ-023 SHALL route nop and any undefined opcode from T2 directly to T0.
REQ-024 SHALL set illegal on an undefined opcode at T2 and hold it until reset.
REQ-025 SHALL route halt from T2 to HALT, where halted=1, all strobes are 0 and the block waits for reset; run is ignored in HALT.
REQ-026 SHALL pulse done for exactly one cycle in the final state of each instruction (T5 for ALU ops, T6 for HI/LO ops, T2 for nop/undefined/halt).
REQ-027 SHALL increment instr_count on each done, wrapping from 0xFFFF to 0x0000.
REQ-028 SHALL, if run falls mid-instruction, complete that instruction and then idle in T0.
REQ-029 SHALL never assert two bus drivers (PCout, ZLowout, ZHighout, MDRout, Rout) in the same cycle.

Reset
REQ-030 SHALL, while clear=0, force state=T0, strobes=0, opcode=0, done=0, halted=0, illegal=0 and instr_count=0 asynchronously, without waiting for a clock edge.
REQ-031 SHALL, on reset asserted in any state including T1 wait or HALT, drop all strobes in the same cycle and resume at T0 on the first edge after clear rises.

Verification
REQ-032 SHALL verify: reset, run=1, mem_ready=1, IR=add(00011) -> T0..T5 in 6 cycles; opcode=00011 in T4 only; done in T5; instr_count=1.
REQ-033 SHALL verify: mem_ready held 0 for 3 cycles in T1 -> T1 lasts 4 cycles, PCin high only in the last, Read/MDRin high in all 4.
REQ-034 SHALL verify: IR=mul(01111) -> LOin in T5, HIin in T6, done only in T6; IR=div(10000) behaves identically.
REQ-035 SHALL verify: IR=11111 -> illegal=1 after T2, return to T0, done pulses; illegal still 1 after a following add.
REQ-036 SHALL verify: IR=halt(11011) -> HALT, halted=1, strobes=0 for 10 cycles with run=1; clear pulse -> T0, halted=0.
REQ-037 SHALL verify: instr_count preloaded to 0xFFFF via 65535 nops, then one nop -> 0x0000; clear=0 during T3 -> strobes=0 immediately.
